mprj_out_arbiter: RTL and testbench



---
 rtl/mprj_arb_pkg.sv | 18 +
 rtl/rr_picker.sv | 38 +++
 rtl/mprj_out_arbiter.sv | 90 +++++++++
 tb/tb_mprj_out_arbiter.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mprj_arb_pkg.sv
// rtl/mprj_arb_pkg.sv - shared state encoding and default parameters for the output arbiter
package mprj_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } arb_state_t;

    localparam int DEF_NREQ        = 4;
    localparam int DEF_WIDTH       = 8;
    localparam int DEF_HOLD_CYCLES = 16;

    // Hold counter must be at least one bit wide even when HOLD_CYCLES is 1.
    function automatic int cnt_width(input int hold_cycles);
        return (hold_cycles > 1) ? $clog2(hold_cycles) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational rotate-priority encoder, search starts at ptr and wraps
module rr_picker
    import mprj_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic                    valid,
    output logic [$clog2(NREQ)-1:0] idx,
    output logic [NREQ-1:0]         onehot
);

    localparam int IW = $clog2(NREQ);

    int             c;
    logic [IW-1:0]  cand;

    // Walk from the farthest candidate back to ptr so the nearest request wins last.
    always_comb begin
        valid = |req;
        idx   = '0;
        c     = 0;
        cand  = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            c = int'(ptr) + i;
            if (c >= NREQ) begin
                c = c - NREQ;
            end
            cand = IW'(c);
            if (req[cand]) begin
                idx = cand;
            end
        end
        onehot = valid ? (NREQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/mprj_out_arbiter.sv
// rtl/mprj_out_arbiter.sv - round-robin arbiter sharing the mprj_io output bank with minimum hold time
module mprj_out_arbiter
    import mprj_arb_pkg::*;
#(
    parameter int NREQ        = DEF_NREQ,
    parameter int WIDTH       = DEF_WIDTH,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic [NREQ-1:0]         req_i,
    input  logic [NREQ*WIDTH-1:0]   data_i,
    output logic [NREQ-1:0]         gnt_o,
    output logic [WIDTH-1:0]        io_out_o,
    output logic [WIDTH-1:0]        io_oeb_o,
    output logic [$clog2(NREQ)-1:0] last_id_o,
    output logic                    busy_o
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = cnt_width(HOLD_CYCLES);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);

    arb_state_t     state;
    arb_state_t     state_next;
    logic [CW-1:0]  hold_cnt;
    logic [IW-1:0]  rr_ptr;
    logic [IW-1:0]  rr_ptr_next;

    logic           pick_valid;
    logic [IW-1:0]  pick_idx;
    logic [NREQ-1:0] pick_onehot;
    logic           grant_now;

    rr_picker #(
        .NREQ (NREQ)
    ) u_picker (
        .req    (req_i),
        .ptr    (rr_ptr),
        .valid  (pick_valid),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    // A grant happens from IDLE, or back-to-back once the hold window has expired.
    assign grant_now   = pick_valid && ((state == ST_IDLE) || (hold_cnt == '0));
    assign rr_ptr_next = (int'(pick_idx) == NREQ - 1) ? '0 : pick_idx + IW'(1);
    assign busy_o      = (state == ST_HOLD);

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (pick_valid) state_next = ST_HOLD;
            ST_HOLD: if ((hold_cnt == '0) && !pick_valid) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            hold_cnt  <= '0;
            rr_ptr    <= '0;
            gnt_o     <= '0;
            io_out_o  <= '0;
            io_oeb_o  <= '1;
            last_id_o <= '0;
        end else begin
            gnt_o <= '0;
            if (grant_now) begin
                io_out_o  <= data_i[int'(pick_idx)*WIDTH +: WIDTH];
                gnt_o     <= pick_onehot;
                last_id_o <= pick_idx;
                rr_ptr    <= rr_ptr_next;
                hold_cnt  <= HOLD_LOAD;
                io_oeb_o  <= '0;
            end else if ((state == ST_HOLD) && (hold_cnt != '0)) begin
                hold_cnt <= hold_cnt - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_mprj_out_arbiter.sv
// tb/tb_mprj_out_arbiter.sv - directed self-checking bench for mprj_out_arbiter
module tb_mprj_out_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  gnt;
    logic [7:0]  io_out;
    logic [7:0]  io_oeb;
    logic [1:0]  last_id;
    logic        busy;

    int total = 0;
    int bad   = 0;

    mprj_out_arbiter #(
        .NREQ        (4),
        .WIDTH       (8),
        .HOLD_CYCLES (16)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .req_i     (req),
        .data_i    (data),
        .gnt_o     (gnt),
        .io_out_o  (io_out),
        .io_oeb_o  (io_oeb),
        .last_id_o (last_id),
        .busy_o    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_out"},  32'(io_out),  32'h00);
        chk({tag, "_oeb"},  32'(io_oeb),  32'hFF);
        chk({tag, "_gnt"},  32'(gnt),     32'h0);
        chk({tag, "_last"}, 32'(last_id), 32'h0);
        chk({tag, "_busy"}, 32'(busy),    32'h0);
    endtask

    initial begin
        rst  = 1'b1;
        req  = 4'b0000;
        data = 32'h0;

        // Reset state, held for 100 idle cycles after release
        #1;
        chk_reset_outputs("rst_hold");
        step(2);
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            chk("idle_oeb", 32'(io_oeb), 32'hFF);
            chk("idle_out", 32'(io_out), 32'h00);
            chk("idle_gnt", 32'(gnt),    32'h0);
        end

        // Single request from requester 0
        data = 32'h0000_0005;
        req  = 4'b0001;
        step(1);
        chk("single_gnt",  32'(gnt),     32'h1);
        chk("single_out",  32'(io_out),  32'h05);
        chk("single_oeb",  32'(io_oeb),  32'h00);
        chk("single_busy", 32'(busy),    32'h1);
        chk("single_last", 32'(last_id), 32'h0);
        req = 4'b0000;
        step(1);
        chk("single_pulse", 32'(gnt), 32'h0);
        for (int i = 2; i < 16; i++) begin
            step(1);
            chk("single_busy_hold", 32'(busy), 32'h1);
        end
        step(1);
        chk("single_idle_busy", 32'(busy),   32'h0);
        chk("single_idle_out",  32'(io_out), 32'h05);
        chk("single_idle_oeb",  32'(io_oeb), 32'h00);

        // Async reset pulse so the next test starts with rr_ptr = 0
        #2 rst = 1'b1;
        #1 chk_reset_outputs("rst_pulse");
        step(1);
        rst = 1'b0;

        // All four requesting continuously
        data = 32'hA3A2_A1A0;
        req  = 4'b1111;
        step(1);
        chk("all_gnt0",  32'(gnt),     32'h1);
        chk("all_out0",  32'(io_out),  32'hA0);
        chk("all_last0", 32'(last_id), 32'h0);
        for (int k = 1; k <= 4; k++) begin
            step(15);
            chk("all_gap_gnt",  32'(gnt),  32'h0);
            chk("all_gap_busy", 32'(busy), 32'h1);
            step(1);
            chk("all_gnt",  32'(gnt),     32'(4'b0001 << (k % 4)));
            chk("all_out",  32'(io_out),  32'(8'hA0 + (k % 4)));
            chk("all_last", 32'(last_id), 32'(k % 4));
        end
        req = 4'b0000;
        step(16);
        chk("all_idle_busy", 32'(busy),   32'h0);
        chk("all_idle_out",  32'(io_out), 32'hA0);

        // Pointer rotation: grant 2, then 0 and 2 compete with rr_ptr = 3
        data = 32'h00C2_00D0;
        req  = 4'b0100;
        step(1);
        chk("rot_gnt2", 32'(gnt),    32'h4);
        chk("rot_out2", 32'(io_out), 32'hC2);
        req = 4'b0101;
        step(15);
        chk("rot_gap", 32'(gnt), 32'h0);
        step(1);
        chk("rot_gnt0",  32'(gnt),     32'h1);
        chk("rot_out0",  32'(io_out),  32'hD0);
        chk("rot_last0", 32'(last_id), 32'h0);
        req = 4'b0100;
        step(16);
        chk("rot_gnt2b", 32'(gnt),    32'h4);
        chk("rot_out2b", 32'(io_out), 32'hC2);
        req = 4'b0000;
        step(16);
        chk("rot_idle", 32'(busy), 32'h0);

        // Withdrawal: requester 1 raises and drops during HOLD
        data = 32'hB300_9900;
        req  = 4'b1000;
        step(1);
        chk("wd_gnt3", 32'(gnt),    32'h8);
        chk("wd_out3", 32'(io_out), 32'hB3);
        req = 4'b0000;
        step(3);
        req = 4'b0010;
        step(5);
        req = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("wd_no_gnt", 32'(gnt), 32'h0);
        end
        chk("wd_idle", 32'(busy),    32'h0);
        chk("wd_out",  32'(io_out),  32'hB3);
        chk("wd_last", 32'(last_id), 32'h3);

        // Reset mid-HOLD, then verify rr_ptr restarted at 0
        data = 32'h0077_0000;
        req  = 4'b0100;
        step(1);
        chk("mid_gnt2", 32'(gnt), 32'h4);
        req = 4'b0000;
        step(4);
        chk("mid_busy", 32'(busy), 32'h1);
        #2 rst = 1'b1;
        #1 chk_reset_outputs("mid_rst");
        step(1);
        rst  = 1'b0;
        data = 32'h3300_0011;
        req  = 4'b1001;
        step(1);
        chk("post_gnt",  32'(gnt),     32'h1);
        chk("post_out",  32'(io_out),  32'h11);
        chk("post_oeb",  32'(io_oeb),  32'h00);
        chk("post_last", 32'(last_id), 32'h0);
        req = 4'b0000;
        step(16);
        chk("post_idle", 32'(busy), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
